// File: rtl/ip_traffic_gen_if.sv
// ip_traffic_gen_if: local-port bundle between a traffic endpoint and its router.
//   master (endpoint): drives packet_out/valid_out, samples ready_in and the
//                      delivery side data_in/valid_in.
//   slave  (router)  : the mirror image.
// packet_t is declared here so both sides share one layout.
interface ip_traffic_gen_if #(
    parameter int WIDTH = 32
);
    typedef struct packed {
        logic [WIDTH-1:0] data;       // {ip_id, seq}
        logic [15:0]      src;        // {X, Y}
        logic [15:0]      dst;        // {x, y}
        logic [31:0]      timestamp;  // cycle of generation
        logic             valid;
    } packet_t;

    packet_t packet_out;
    logic    valid_out;
    logic    ready_in;
    packet_t data_in;
    logic    valid_in;

    modport master (output packet_out, valid_out, input ready_in, data_in, valid_in);
    modport slave  (input packet_out, valid_out, output ready_in, data_in, valid_in);
endinterface

// File: rtl/ip_traffic_gen.sv
// ip_traffic_gen: NoC traffic endpoint for one router local port.
// Generates packets under a selectable injection scheme into a small source
// queue, so router backpressure never changes the offered load; drops are
// counted when the queue is full. Destinations come from a seeded Galois LFSR.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   X, Y, ip_id         own coordinates and endpoint id
//   gen_mode, inj_rate  injection scheme select / random-mode threshold
//   bus (master)        packet_out/valid_out/ready_in, data_in/valid_in
//   tx_count, drop_count, rx_count, misroute_count, lat_sum, lat_max
// Build option: define IP_TRAFFIC_GEN_STATS_EN to compile in the receive-side
// statistics; otherwise rx_count/misroute_count/lat_sum/lat_max read 0.
module ip_traffic_gen #(
    parameter int          WIDTH        = 32,
    parameter int          MESH_DIM     = 2,
    parameter int          QUEUE_DEPTH  = 4,
    parameter int          BURST_PERIOD = 30,
    parameter int          BURST_ON     = 10,
    parameter int          PERIOD       = 5,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           X,
    input  logic [7:0]           Y,
    input  logic [WIDTH/2-1:0]   ip_id,
    input  logic [2:0]           gen_mode,
    input  logic [3:0]           inj_rate,
    ip_traffic_gen_if.master     bus,
    output logic [31:0]          tx_count,
    output logic [31:0]          drop_count,
    output logic [31:0]          rx_count,
    output logic [31:0]          misroute_count,
    output logic [31:0]          lat_sum,
    output logic [31:0]          lat_max
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [15:0]      src;
        logic [15:0]      dst;
        logic [31:0]      timestamp;
        logic             valid;
    } packet_t;

    localparam int          HW        = WIDTH / 2;
    localparam int          AW        = $clog2(QUEUE_DEPTH);
    localparam logic [31:0] NR        = 32'(MESH_DIM * MESH_DIM);
    localparam logic [31:0] MD        = 32'(MESH_DIM);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(QUEUE_DEPTH);
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---------------- state ----------------
    logic [31:0]   cyc_q, cyc_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [HW-1:0] seq_q, seq_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    packet_t       mem_q [QUEUE_DEPTH];
    packet_t       mem_d [QUEUE_DEPTH];
    logic [31:0]   tx_q, tx_d, drop_q, drop_d;

    // ---------------- generation strobe ----------------
    logic gen;
    always_comb begin
        gen = 1'b0;
        case (gen_mode)
            3'b000:  gen = lfsr_q[7:4] < inj_rate;
            3'b001:  gen = (cyc_q % 32'(BURST_PERIOD)) < 32'(BURST_ON);
            3'b010:  gen = (cyc_q % 32'(PERIOD)) == 32'd0;
            3'b011:  gen = cyc_q < 32'(BURST_ON);
            3'b100:  gen = ~cyc_q[0];
            3'b101:  gen = 1'b1;
            default: gen = 1'b0;
        endcase
    end

    // ---------------- new packet ----------------
    logic [31:0] idx, self_idx;
    packet_t     new_pkt;
    always_comb begin
        self_idx = {24'h0, Y} * MD + {24'h0, X};
        idx      = {16'h0, lfsr_q} % NR;
        // Never address ourselves: bump to the next router.
        if (idx == self_idx) idx = (idx + 32'd1) % NR;
        new_pkt           = '0;
        new_pkt.data      = {ip_id, seq_q};
        new_pkt.src       = {X, Y};
        new_pkt.dst       = {8'(idx % MD), 8'(idx / MD)};
        new_pkt.timestamp = cyc_q;
        new_pkt.valid     = 1'b1;
    end

    // ---------------- source queue ----------------
    logic empty, full, pop, push, drop;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign pop   = !empty && bus.ready_in;
    // A simultaneous pop frees a slot, so a full queue still accepts.
    assign push  = gen && (!full || pop);
    assign drop  = gen && full && !pop;

    always_comb begin
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        seq_d  = seq_q;
        tx_d   = tx_q;
        drop_d = drop_q;
        // When full, wr_q == rd_q: the slot written is the one leaving now.
        if (push) begin
            mem_d[wr_q] = new_pkt;
            wr_d        = wr_q + AW'(1);
            seq_d       = seq_q + HW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
            tx_d = sat_inc(tx_q);
        end
        if (drop) drop_d = sat_inc(drop_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            lfsr_q <= LFSR_INIT;
            seq_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            tx_q   <= '0;
            drop_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cyc_q  <= cyc_d;
            lfsr_q <= lfsr_d;
            seq_q  <= seq_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            tx_q   <= tx_d;
            drop_q <= drop_d;
            mem_q  <= mem_d;
        end
    end

    assign bus.valid_out  = !empty;
    assign bus.packet_out = empty ? '0 : mem_q[rd_q];
    assign tx_count       = tx_q;
    assign drop_count     = drop_q;

    // ---------------- receive-side statistics ----------------
`ifdef IP_TRAFFIC_GEN_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    packet_t     rx_pkt;
    logic [31:0] lat;
    logic [31:0] rx_q, rx_d, mis_q, mis_d, sum_q, sum_d, max_q, max_d;
    logic        unused_rx;

    assign rx_pkt    = bus.data_in;
    assign unused_rx = ^{rx_pkt.data, rx_pkt.src, rx_pkt.valid};
    // Modular subtraction keeps latency right across a cyc wrap.
    assign lat       = cyc_q - rx_pkt.timestamp;

    always_comb begin
        rx_d  = rx_q;
        mis_d = mis_q;
        sum_d = sum_q;
        max_d = max_q;
        if (bus.valid_in) begin
            rx_d  = sat_inc(rx_q);
            sum_d = sat_add(sum_q, lat);
            if (lat > max_q)            max_d = lat;
            if (rx_pkt.dst != {X, Y})   mis_d = sat_inc(mis_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q  <= '0;
            mis_q <= '0;
            sum_q <= '0;
            max_q <= '0;
        end else begin
            rx_q  <= rx_d;
            mis_q <= mis_d;
            sum_q <= sum_d;
            max_q <= max_d;
        end
    end

    assign rx_count       = rx_q;
    assign misroute_count = mis_q;
    assign lat_sum        = sum_q;
    assign lat_max        = max_q;
`else
    logic unused_rx;
    assign unused_rx      = ^{bus.data_in, bus.valid_in};
    assign rx_count       = '0;
    assign misroute_count = '0;
    assign lat_sum        = '0;
    assign lat_max        = '0;
`endif
endmodule

// File: tb/tb_ip_traffic_gen.sv
`timescale 1ns/1ps
module tb_ip_traffic_gen;
    localparam int          WIDTH = 32;
    localparam int          MD    = 2;
    localparam int          NR    = MD * MD;
    localparam int          DEPTH = 4;
    localparam int          BP    = 30;
    localparam int          BON   = 10;
    localparam int          PER   = 5;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] timestamp;
        logic        valid;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  X = 8'd0, Y = 8'd0;
    logic [15:0] ip_id = 16'h1234;
    logic [2:0]  gen_mode = 3'b110;
    logic [3:0]  inj_rate = 4'd0;
    logic [31:0] tx_count, drop_count, rx_count, misroute_count, lat_sum, lat_max;

    ip_traffic_gen_if #(.WIDTH(WIDTH)) bus();

    always #5 clk = ~clk;

    ip_traffic_gen #(
        .WIDTH(WIDTH), .MESH_DIM(MD), .QUEUE_DEPTH(DEPTH), .BURST_PERIOD(BP),
        .BURST_ON(BON), .PERIOD(PER), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .ip_id(ip_id),
        .gen_mode(gen_mode), .inj_rate(inj_rate), .bus(bus),
        .tx_count(tx_count), .drop_count(drop_count), .rx_count(rx_count),
        .misroute_count(misroute_count), .lat_sum(lat_sum), .lat_max(lat_max)
    );

    // ---------------- behavioural model ----------------
    pkt_t        mq[$];
    logic [31:0] m_cyc, m_tx, m_drop, m_rx, m_mis, m_sum, m_max;
    logic [15:0] m_lfsr, m_seq;
    int          n_checks = 0, n_err = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cyc = 0; m_lfsr = SEED; m_seq = 0;
        m_tx = 0; m_drop = 0; m_rx = 0; m_mis = 0; m_sum = 0; m_max = 0;
    endtask

    // One clock edge worth of behaviour, from the pre-edge model state and
    // the inputs the bench is holding.
    task automatic model_step();
        bit          g;
        int unsigned idx, self_i;
        pkt_t        p, d;
        logic [31:0] lat;
        longint      s;
        case (gen_mode)
            3'd0:    g = (m_lfsr[7:4] < inj_rate);
            3'd1:    g = (m_cyc % BP) < BON;
            3'd2:    g = (m_cyc % PER) == 0;
            3'd3:    g = m_cyc < BON;
            3'd4:    g = (m_cyc % 2) == 0;
            3'd5:    g = 1'b1;
            default: g = 1'b0;
        endcase
        if (mq.size() > 0 && bus.ready_in) begin
            void'(mq.pop_front());
            m_tx = sinc(m_tx);
        end
        if (g) begin
            if (mq.size() < DEPTH) begin
                idx    = m_lfsr % NR;
                self_i = Y * MD + X;
                if (idx == self_i) idx = (idx + 1) % NR;
                p.data      = {ip_id, m_seq};
                p.src       = {X, Y};
                p.dst       = {8'(idx % MD), 8'(idx / MD)};
                p.timestamp = m_cyc;
                p.valid     = 1'b1;
                mq.push_back(p);
                m_seq++;
            end else begin
                m_drop = sinc(m_drop);
            end
        end
`ifdef IP_TRAFFIC_GEN_STATS_EN
        if (bus.valid_in) begin
            d     = bus.data_in;
            lat   = m_cyc - d.timestamp;
            m_rx  = sinc(m_rx);
            s     = longint'(m_sum) + longint'(lat);
            m_sum = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            if (lat > m_max) m_max = lat;
            if (d.dst != {X, Y}) m_mis = sinc(m_mis);
        end
`endif
        m_cyc++;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        pkt_t exp_p;
        if (chk_en) begin
            exp_p = (mq.size() > 0) ? mq[0] : '0;
            chk("valid_out",      bus.valid_out, mq.size() > 0);
            chk("packet_out",     bus.packet_out, exp_p);
            chk("tx_count",       tx_count, m_tx);
            chk("drop_count",     drop_count, m_drop);
            chk("rx_count",       rx_count, m_rx);
            chk("misroute_count", misroute_count, m_mis);
            chk("lat_sum",        lat_sum, m_sum);
            chk("lat_max",        lat_max, m_max);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing mid-phase; outputs must clear at once.
    task automatic do_reset();
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_out",  bus.valid_out, 0);
        chk("rst_packet_out", bus.packet_out, 0);
        chk("rst_tx",         tx_count, 0);
        chk("rst_drop",       drop_count, 0);
        chk("rst_rx",         rx_count, 0);
        chk("rst_mis",        misroute_count, 0);
        chk("rst_lat_sum",    lat_sum, 0);
        chk("rst_lat_max",    lat_max, 0);
        @(negedge clk);
        model_reset();
        bus.valid_in = 1'b0;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        pkt_t p;
        int   k, bad;
        bus.ready_in = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_reset();
        do_reset();

        // A: always-generate, always-ready.
        gen_mode = 3'b101; bus.ready_in = 1'b1; X = 0; Y = 0;
        tick();
        p = bus.packet_out;
        chk("A_valid_first", bus.valid_out, 1);
        chk("A_dst_first",   p.dst, 16'h0100);
        for (int i = 2; i <= 5; i++) tick();
        p = bus.packet_out;
        chk("A_dst_fifth",   p.dst, 16'h0001);
        for (int i = 6; i <= 20; i++) tick();
        chk("A_tx_19",   tx_count, 19);
        chk("A_drop_0",  drop_count, 0);

        // B: stall 10 cycles, then drain in order.
        do_reset();
        gen_mode = 3'b101; bus.ready_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        p = bus.packet_out;
        chk("B_drop_6",  drop_count, 6);
        chk("B_src",     p.src, 16'h0000);
        chk("B_ip_id",   p.data[31:16], 16'h1234);
        for (int j = 0; j < 8; j++) begin
            p = bus.packet_out;
            chk("B_seq_order", p.data[15:0], j);
            bus.ready_in = 1'b1;
            tick();
        end
        chk("B_drop_hold", drop_count, 6);

        // C: constant rate, timestamps 0,5,10...
        do_reset();
        gen_mode = 3'b010; bus.ready_in = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.valid_out) begin
                p = bus.packet_out;
                chk("C_timestamp", p.timestamp, 32'(5 * k));
                k++;
            end
        end
        chk("C_pkt_count", k, 8);

        // D: self-avoidance, two seeded runs.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            gen_mode = 3'b101; bus.ready_in = 1'b1; X = 0; Y = 0;
            bad = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                p = bus.packet_out;
                if (p.dst == 16'h0000) bad++;
            end
            chk("D_self_dst", bad, 0);
        end

        // E: receive statistics, incl. a cyc wrap latency.
        do_reset();
        gen_mode = 3'b110; bus.ready_in = 1'b0;
        p = '0; p.valid = 1'b1; p.dst = 16'h0101; p.timestamp = m_cyc - 32'd7;
        bus.data_in = p; bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
`ifdef IP_TRAFFIC_GEN_STATS_EN
        chk("E_rx_1", rx_count, 1);
        chk("E_sum_7", lat_sum, 7);
        chk("E_max_7", lat_max, 7);
        chk("E_mis_1", misroute_count, 1);
`else
        chk("E_rx_off", rx_count, 0);
`endif
        tick(); tick();
        p.dst = 16'h0000; p.timestamp = 32'hFFFF_FFFE;
        bus.data_in = p; bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
`ifdef IP_TRAFFIC_GEN_STATS_EN
        chk("E_rx_2",   rx_count, 2);
        chk("E_sum_12", lat_sum, 12);
        chk("E_max_7b", lat_max, 7);
        chk("E_mis_1b", misroute_count, 1);
`else
        chk("E_sum_off", lat_sum, 0);
`endif

        // F: reset with 3 queued packets, LFSR restarts.
        do_reset();
        gen_mode = 3'b101; bus.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("F_valid_before", bus.valid_out, 1);
        do_reset();
        bus.ready_in = 1'b1;
        tick();
        p = bus.packet_out;
        chk("F_dst_restart", p.dst, 16'h0100);

        // G: randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 1500 == 1499) do_reset();
            if (i % 97 == 0) begin
                gen_mode = 3'($urandom_range(0, 7));
                inj_rate = 4'($urandom);
            end
            X = 8'($urandom_range(0, 1));
            Y = 8'($urandom_range(0, 1));
            bus.ready_in = ($urandom_range(0, 3) != 0);
            bus.valid_in = ($urandom_range(0, 2) == 0);
            p.data  = $urandom;
            p.src   = 16'($urandom);
            p.dst   = {7'd0, 1'($urandom), 7'd0, 1'($urandom)};
            p.valid = 1'b1;
            p.timestamp = ($urandom_range(0, 1) == 0) ? m_cyc - 32'($urandom_range(0, 100)) : $urandom;
            bus.data_in = p;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
